stereo_matrix_interp_48_192: RTL and testbench

Upstream stage of the 192 kHz multiplex/FM block. It takes 48 kHz left/right audio and forms the mid (L+R)/2 and side (L−R)/2 signals. It then linearly interpolates both by 4 and presents them as 18-bit samples, one per 192 kHz strobe, on LI_LEFT/LI_RIGHT of the multiplex stage with a one-cycle valid pulse. It also flags missing input samples.

---
 rtl/stereo_matrix_interp_48_192_pkg.sv | 20 ++
 rtl/stereo_matrix_interp_48_192_if.sv | 31 +++
 rtl/stereo_matrix_interp_48_192_lin_interp4.sv | 60 ++++++
 rtl/stereo_matrix_interp_48_192.sv | 105 ++++++++++
 tb/tb_stereo_matrix_interp_48_192.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/stereo_matrix_interp_48_192_pkg.sv
// Shared constants and types for the 48 kHz -> 192 kHz stereo matrix /
// interpolation stage and the multiplex stage that follows it.
//   FM_NBITS   : audio sample width (signed two's complement)
//   FM_UPS     : interpolation factor (shift-based, fixed at 4)
//   FM_PHASE_W : width of the interpolation phase counter
package stereo_matrix_interp_48_192_pkg;

    localparam int FM_NBITS   = 18;
    localparam int FM_UPS     = 4;
    localparam int FM_PHASE_W = 2;

    typedef logic [FM_PHASE_W-1:0] phase_t;

    // Channel index into the per-channel packed arrays of the top.
    typedef enum logic {
        CH_MID  = 1'b0,
        CH_SIDE = 1'b1
    } chan_e;

endpackage

// File: rtl/stereo_matrix_interp_48_192_if.sv
// Sample/strobe bus between clockgen + audio source (master) and the
// stereo matrix interpolator (slave).
//   clken_48 / clken_192   : one-cycle rate strobes
//   LEFT_IN / RIGHT_IN     : signed audio, sampled on clken_48
//   LI_MID / LI_SIDE       : interpolated mid/side samples
//   ready_interp           : one-cycle pulse, LI_MID/LI_SIDE updated
//   err_underrun           : sticky missing-input-sample flag
interface stereo_matrix_interp_48_192_if
    import stereo_matrix_interp_48_192_pkg::*;
#(
    parameter int NBITS = FM_NBITS
);
    logic                    clken_48;
    logic                    clken_192;
    logic signed [NBITS-1:0] LEFT_IN;
    logic signed [NBITS-1:0] RIGHT_IN;
    logic signed [NBITS-1:0] LI_MID;
    logic signed [NBITS-1:0] LI_SIDE;
    logic                    ready_interp;
    logic                    err_underrun;

    modport master (
        output clken_48, clken_192, LEFT_IN, RIGHT_IN,
        input  LI_MID, LI_SIDE, ready_interp, err_underrun
    );

    modport slave (
        input  clken_48, clken_192, LEFT_IN, RIGHT_IN,
        output LI_MID, LI_SIDE, ready_interp, err_underrun
    );
endinterface

// File: rtl/stereo_matrix_interp_48_192_lin_interp4.sv
// One channel of the x4 linear interpolator.
// Holds the previous and current 48 kHz sample and forms
//   y = prev + (((cur - prev) * k) >>> SHIFT)
// combinationally for the phase k supplied by the top.
// Ports:
//   clock, reset : system clock, async active-low reset
//   load         : 48 kHz strobe, shifts cur->prev and captures din
//   din          : new matrixed sample
//   k            : interpolation phase (0..3)
//   y            : interpolated sample (combinational)
module stereo_matrix_interp_48_192_lin_interp4 #(
    parameter int NBITS = 18,
    parameter int SHIFT = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic signed [NBITS-1:0] din,
    input  logic [1:0]              k,
    output logic signed [NBITS-1:0] y
);
    localparam int DW = NBITS + 1;  // cur - prev
    localparam int PW = NBITS + 3;  // (cur - prev) * 3

    logic signed [NBITS-1:0] prev, cur;
    logic signed [DW-1:0]    diff;
    logic signed [PW-1:0]    diff_x, prod, step, sum;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev <= '0;
            cur  <= '0;
        end else if (load) begin
            prev <= cur;
            cur  <= din;
        end
    end

    // k is at most 3, so the product is a shift/add of the difference.
    // The arithmetic shift floors toward -inf, which keeps y between
    // prev and cur for either sign of the difference.
    always_comb begin
        diff   = DW'(cur) - DW'(prev);
        diff_x = PW'(diff);
        prod   = '0;
        if (k[0]) prod = prod + diff_x;
        if (k[1]) prod = prod + (diff_x <<< 1);
        step   = prod >>> SHIFT;
        sum    = PW'(prev) + step;
        y      = sum[NBITS-1:0];
    end

    // The bits dropped by the truncation must be pure sign extension.
    always_comb begin
        if (reset) begin
            assert (sum[PW-1:NBITS-1] == {(PW-NBITS+1){sum[NBITS-1]}});
        end
    end

endmodule

// File: rtl/stereo_matrix_interp_48_192.sv
// Stereo matrix + x4 linear interpolator, 48 kHz in / 192 kHz out.
// Forms mid = (L+R)>>>1 and side = (L-R)>>>1 on each clken_48, then
// presents one interpolated mid/side pair per clken_192, one clock after
// the strobe, with a one-cycle ready_interp pulse.
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of stereo_matrix_interp_48_192_if (strobes,
//            LEFT_IN/RIGHT_IN in; LI_MID/LI_SIDE/ready_interp/
//            err_underrun out)
module stereo_matrix_interp_48_192
    import stereo_matrix_interp_48_192_pkg::*;
#(
    parameter int NBITS = FM_NBITS,
    parameter int UPS   = FM_UPS
) (
    input  logic                          clock,
    input  logic                          reset,
    stereo_matrix_interp_48_192_if.slave  bus
);
    localparam int     SW        = NBITS + 1;
    localparam int     SHIFT     = $clog2(UPS);
    localparam phase_t PHASE_MAX = phase_t'(UPS - 1);

    logic signed [SW-1:0]       sum_lr, dif_lr;
    logic [1:0][NBITS-1:0]      mat;   // indexed by chan_e
    logic [1:0][NBITS-1:0]      y;
    phase_t                     k;
    logic                       fresh;  // clken_48 seen, no clken_192 yet
    logic                       stb_d;
    logic                       err;
    logic                       rdy;
    logic signed [NBITS-1:0]    out_mid, out_side;

    // Matrix: 19-bit sum/difference, then halve; always fits NBITS.
    always_comb begin
        sum_lr          = SW'(bus.LEFT_IN) + SW'(bus.RIGHT_IN);
        dif_lr          = SW'(bus.LEFT_IN) - SW'(bus.RIGHT_IN);
        mat[CH_MID]     = sum_lr[SW-1:1];
        mat[CH_SIDE]    = dif_lr[SW-1:1];
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        stereo_matrix_interp_48_192_lin_interp4 #(
            .NBITS (NBITS),
            .SHIFT (SHIFT)
        ) u_interp (
            .clock (clock),
            .reset (reset),
            .load  (bus.clken_48),
            .din   (mat[ch]),
            .k     (k),
            .y     (y[ch])
        );
    end

    // Phase control. A clken_48 restarts the frame at phase 0. When it
    // arrives a clock ahead of its clken_192, that strobe must still show
    // phase 0, so 'fresh' swallows the increment of the first strobe and
    // the output matches the coincident case.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            k     <= '0;
            fresh <= 1'b0;
            stb_d <= 1'b0;
            err   <= 1'b0;
        end else begin
            stb_d <= bus.clken_192;
            if (bus.clken_48) begin
                k     <= '0;
                fresh <= !bus.clken_192;
            end else if (bus.clken_192) begin
                if (fresh) begin
                    fresh <= 1'b0;
                end else if (k != PHASE_MAX) begin
                    k <= k + phase_t'(1);
                end else begin
                    err <= 1'b1;  // input starved: hold last phase
                end
            end
        end
    end

    // Output register: loads one clock after each clken_192, from the
    // state that strobe produced.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_mid  <= '0;
            out_side <= '0;
            rdy      <= 1'b0;
        end else begin
            rdy <= stb_d;
            if (stb_d) begin
                out_mid  <= y[CH_MID];
                out_side <= y[CH_SIDE];
            end
        end
    end

    assign bus.LI_MID       = out_mid;
    assign bus.LI_SIDE      = out_side;
    assign bus.ready_interp = rdy;
    assign bus.err_underrun = err;

endmodule

// File: tb/tb_stereo_matrix_interp_48_192.sv
// Self-checking bench for stereo_matrix_interp_48_192: directed cases with
// literal expectations plus randomized frames compared every cycle against
// an integer reference model.
module tb_stereo_matrix_interp_48_192;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    stereo_matrix_interp_48_192_if #(.NBITS(18)) bus ();

    stereo_matrix_interp_48_192 #(.NBITS(18), .UPS(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int floor_div(input int num, input int den);
        if (num >= 0) return num / den;
        return -((-num + den - 1) / den);
    endfunction

    function automatic int interp(input int p, input int c, input int kk);
        return p + floor_div((c - p) * kk, 4);
    endfunction

    int m_prev[2], m_cur[2], m_k;
    bit m_fresh, m_err, m_stbd, e_rdy;
    int e_out[2];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                m_prev[c] = 0; m_cur[c] = 0; e_out[c] = 0;
            end
            m_k = 0; m_fresh = 0; m_err = 0; m_stbd = 0; e_rdy = 0;
        end else begin
            int l, r;
            l = int'(bus.LEFT_IN);
            r = int'(bus.RIGHT_IN);
            if (m_stbd)
                for (int c = 0; c < 2; c++) e_out[c] = interp(m_prev[c], m_cur[c], m_k);
            e_rdy = m_stbd;
            if (bus.clken_48) begin
                m_prev[0] = m_cur[0]; m_cur[0] = floor_div(l + r, 2);
                m_prev[1] = m_cur[1]; m_cur[1] = floor_div(l - r, 2);
                m_k = 0;
                m_fresh = !bus.clken_192;
            end else if (bus.clken_192) begin
                if (m_fresh) m_fresh = 0;
                else if (m_k < 3) m_k++;
                else m_err = 1;
            end
            m_stbd = bus.clken_192;
        end
    end

    always @(negedge clock) begin
        chk("cyc_mid",  int'(bus.LI_MID),  e_out[0]);
        chk("cyc_side", int'(bus.LI_SIDE), e_out[1]);
        chk("cyc_rdy",  int'(bus.ready_interp), int'(e_rdy));
        chk("cyc_err",  int'(bus.err_underrun), int'(m_err));
    end

    // ---------------- output capture ----------------
    int q_mid[$], q_side[$], q_err[$];

    always @(negedge clock) begin
        if (bus.ready_interp === 1'b1) begin
            q_mid.push_back(int'(bus.LI_MID));
            q_side.push_back(int'(bus.LI_SIDE));
            q_err.push_back(int'(bus.err_underrun));
        end
    end

    task automatic q_clear();
        q_mid.delete(); q_side.delete(); q_err.delete();
    endtask

    task automatic chk_q(input string name, input int idx, input int em, input int es);
        if (idx >= q_mid.size()) begin
            nchk++; nerr++;
            $display("FAIL %s[%0d]: missing output, got %0d samples", name, idx, q_mid.size());
        end else begin
            chk($sformatf("%s_mid[%0d]", name, idx),  q_mid[idx],  em);
            chk($sformatf("%s_side[%0d]", name, idx), q_side[idx], es);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input bit c48, input bit c192, input int l, input int r);
        bus.clken_48  = c48;
        bus.clken_192 = c192;
        if (c48) begin
            bus.LEFT_IN  = 18'(l);
            bus.RIGHT_IN = 18'(r);
        end else begin
            bus.LEFT_IN  = 18'($urandom);
            bus.RIGHT_IN = 18'($urandom);
        end
        @(negedge clock);
        bus.clken_48  = 1'b0;
        bus.clken_192 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.LEFT_IN  = 18'($urandom);
            bus.RIGHT_IN = 18'($urandom);
            @(negedge clock);
        end
    endtask

    task automatic frame(input int l, input int r, input int n, input bit early, input bit rgap);
        if (early) begin
            drive(1'b1, 1'b0, l, r);
            drive(1'b0, 1'b1, 0, 0);
        end else begin
            drive(1'b1, 1'b1, l, r);
        end
        for (int i = 1; i < n; i++) begin
            idle(rgap ? int'($urandom_range(1, 3)) : 1);
            drive(1'b0, 1'b1, 0, 0);
        end
        idle(2);
    endtask

    int ea_mid[8]  = '{0, 150, 300, 450, 600, 600, 600, 600};
    int ea_side[8] = '{0, 100, 200, 300, 400, 400, 400, 400};
    int eb_mid[5]  = '{0, 100, 200, 300, 400};
    int ec_mid[4]  = '{131071, 65535, -1, -65537};
    int ee_mid[6]  = '{600, 550, 500, 450, 450, 450};

    initial begin
        bus.clken_48 = 1'b0; bus.clken_192 = 1'b0;
        bus.LEFT_IN = '0; bus.RIGHT_IN = '0;
        repeat (2) @(negedge clock);
        chk("rst_mid",  int'(bus.LI_MID), 0);
        chk("rst_side", int'(bus.LI_SIDE), 0);
        chk("rst_rdy",  int'(bus.ready_interp), 0);
        chk("rst_err",  int'(bus.err_underrun), 0);
        #2 reset = 1'b1;
        @(negedge clock);

        // Two frames of L=1000, R=200: ramp from reset value, then constant.
        q_clear();
        frame(1000, 200, 4, 1'b0, 1'b0);
        frame(1000, 200, 4, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) chk_q("lr", i, ea_mid[i], ea_side[i]);
        chk("lr_count", q_mid.size(), 8);

        // Mid ramp 0 -> 400.
        frame(0, 0, 4, 1'b0, 1'b1);
        q_clear();
        frame(400, 400, 4, 1'b0, 1'b1);
        frame(400, 400, 1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) chk_q("ramp", i, eb_mid[i], 0);

        // Full-scale swing, no wrap.
        frame(131071, 131071, 4, 1'b0, 1'b1);
        q_clear();
        frame(-131072, -131072, 4, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) chk_q("fs", i, ec_mid[i], 0);
        chk("fs_err", int'(bus.err_underrun), 0);

        // clken_48 one clock ahead of its clken_192 behaves like coincident.
        @(negedge clock); #2 reset = 1'b0;
        @(negedge clock); #2 reset = 1'b1;
        @(negedge clock);
        q_clear();
        frame(1000, 200, 4, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) chk_q("early", i, ea_mid[i], ea_side[i]);

        // Underrun: six strobes on one input sample.
        q_clear();
        frame(800, 0, 6, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) chk_q("udr", i, ee_mid[i], 400);
        if (q_err.size() >= 5) begin
            chk("udr_err_s4", q_err[3], 0);
            chk("udr_err_s5", q_err[4], 1);
        end else begin
            chk("udr_err_count", q_err.size(), 6);
        end
        frame(800, 0, 4, 1'b0, 1'b1);
        chk("udr_sticky", int'(bus.err_underrun), 1);

        // Asynchronous reset between clock edges.
        #3 reset = 1'b0;
        #1;
        chk("arst_mid",  int'(bus.LI_MID), 0);
        chk("arst_side", int'(bus.LI_SIDE), 0);
        chk("arst_rdy",  int'(bus.ready_interp), 0);
        chk("arst_err",  int'(bus.err_underrun), 0);
        @(negedge clock); #2 reset = 1'b1;
        @(negedge clock);
        idle(3);
        chk("arst_norpt", int'(bus.ready_interp), 0);
        drive(1'b0, 1'b1, 0, 0);
        chk("arst_rdy_lat0", int'(bus.ready_interp), 0);
        @(negedge clock);
        chk("arst_rdy_lat1", int'(bus.ready_interp), 1);
        @(negedge clock);
        chk("arst_rdy_lat2", int'(bus.ready_interp), 0);

        // Randomized frames, checked every cycle against the model.
        for (int f = 0; f < 80; f++) begin
            int l, r;
            l = int'($urandom_range(0, 262143)) - 131072;
            r = int'($urandom_range(0, 262143)) - 131072;
            frame(l, r, int'($urandom_range(2, 6)), 1'($urandom_range(0, 1)), 1'b1);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
